// File: rtl/voice_mixer.sv
// Three-voice sample mixer: snapshot on request, accumulate voice by voice, then
// attenuate with an arithmetic shift and saturate into a registered output sample.
module voice_mixer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] voice_sample_0,
  input  logic [WIDTH-1:0] voice_sample_1,
  input  logic [WIDTH-1:0] voice_sample_2,
  input  logic [2:0]       voice_active,
  input  logic [1:0]       master_shift,
  input  logic             generate_next_sample,
  input  logic             clip_clear,
  output logic [WIDTH-1:0] mix_sample,
  output logic             mix_valid,
  output logic             busy,
  output logic             clip,
  output logic             overrun
);

  // Two guard bits hold the worst-case sum of three full-scale voices.
  localparam int unsigned AccW = WIDTH + 2;

  localparam logic signed [AccW-1:0] MaxVal = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [AccW-1:0] MinVal = {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StAcc0, StAcc1, StAcc2, StSat} state_e;

  state_e                   state_q, state_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic signed [WIDTH-1:0]  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [2:0]               active_q, active_d;
  logic [1:0]               shift_q, shift_d;
  logic [WIDTH-1:0]         mix_q, mix_d;
  logic                     valid_q, valid_d;
  logic                     clip_q, clip_d;
  logic                     overrun_q, overrun_d;

  logic signed [AccW-1:0]   addend;
  logic signed [AccW-1:0]   shifted;
  logic signed [AccW-1:0]   sat;
  logic                     clip_set;
  logic                     overrun_set;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    active_d    = active_q;
    shift_d     = shift_q;
    mix_d       = mix_q;
    valid_d     = 1'b0;
    clip_set    = 1'b0;
    addend      = '0;
    shifted     = acc_q >>> shift_q;
    sat         = shifted;

    if (shifted > MaxVal) begin
      sat = MaxVal;
    end else if (shifted < MinVal) begin
      sat = MinVal;
    end

    unique case (state_q)
      StIdle: begin
        if (generate_next_sample) begin
          s0_d     = voice_sample_0;
          s1_d     = voice_sample_1;
          s2_d     = voice_sample_2;
          active_d = voice_active;
          shift_d  = master_shift;
          acc_d    = '0;
          state_d  = StAcc0;
        end
      end
      StAcc0: begin
        if (active_q[0]) addend = AccW'(s0_q);
        acc_d   = acc_q + addend;
        state_d = StAcc1;
      end
      StAcc1: begin
        if (active_q[1]) addend = AccW'(s1_q);
        acc_d   = acc_q + addend;
        state_d = StAcc2;
      end
      StAcc2: begin
        if (active_q[2]) addend = AccW'(s2_q);
        acc_d   = acc_q + addend;
        state_d = StSat;
      end
      StSat: begin
        mix_d    = sat[WIDTH-1:0];
        valid_d  = 1'b1;
        clip_set = (sat != shifted);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Requests while the FSM is anywhere but idle (including SAT) are dropped.
    overrun_set = generate_next_sample && (state_q != StIdle);

    // A set event in the same cycle as a clear wins.
    clip_d    = clip_set    ? 1'b1 : (clip_clear ? 1'b0 : clip_q);
    overrun_d = overrun_set ? 1'b1 : (clip_clear ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      s0_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      active_q  <= '0;
      shift_q   <= '0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      active_q  <= active_d;
      shift_q   <= shift_d;
      mix_q     <= mix_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  assign mix_sample = mix_q;
  assign mix_valid  = valid_q;
  assign busy       = (state_q != StIdle);
  assign clip       = clip_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer: hand-computed mixes, saturation,
// shift rounding, overrun handling, snapshot isolation and mid-mix reset.
module tb_voice_mixer;

  typedef logic signed [31:0] val_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] voice_sample_0, voice_sample_1, voice_sample_2;
  logic [2:0]  voice_active;
  logic [1:0]  master_shift;
  logic        generate_next_sample;
  logic        clip_clear;
  logic [15:0] mix_sample;
  logic        mix_valid;
  logic        busy;
  logic        clip;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int pulses;

  voice_mixer #(.WIDTH(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .voice_sample_0      (voice_sample_0),
    .voice_sample_1      (voice_sample_1),
    .voice_sample_2      (voice_sample_2),
    .voice_active        (voice_active),
    .master_shift        (master_shift),
    .generate_next_sample(generate_next_sample),
    .clip_clear          (clip_clear),
    .mix_sample          (mix_sample),
    .mix_valid           (mix_valid),
    .busy                (busy),
    .clip                (clip),
    .overrun             (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input val_t obs, input val_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1; issues one request and checks the full 5-cycle mix.
  task automatic run_mix(input string tag, input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [2:0] m, input logic [1:0] sh,
                         input val_t exp_sample, input logic exp_clip);
    voice_sample_0       = v0;
    voice_sample_1       = v1;
    voice_sample_2       = v2;
    voice_active         = m;
    master_shift         = sh;
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    check({tag, "_busy"}, val_t'(busy), 1);
    repeat (3) tick();
    check({tag, "_early_valid"}, val_t'(mix_valid), 0);
    tick();
    check({tag, "_valid"}, val_t'(mix_valid), 1);
    check({tag, "_sample"}, val_t'($signed(mix_sample)), exp_sample);
    check({tag, "_clip"}, val_t'(clip), val_t'(exp_clip));
    tick();
    check({tag, "_pulse_end"}, val_t'(mix_valid), 0);
    check({tag, "_hold"}, val_t'($signed(mix_sample)), exp_sample);
  endtask

  initial begin
    reset                = 1'b0;
    voice_sample_0       = '0;
    voice_sample_1       = '0;
    voice_sample_2       = '0;
    voice_active         = '0;
    master_shift         = '0;
    generate_next_sample = 1'b0;
    clip_clear           = 1'b0;
    #2;
    check("rst_sample", val_t'($signed(mix_sample)), 0);
    check("rst_valid", val_t'(mix_valid), 0);
    check("rst_busy", val_t'(busy), 0);
    check("rst_clip", val_t'(clip), 0);
    check("rst_overrun", val_t'(overrun), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    run_mix("basic", 16'd1000, 16'd2000, -16'sd500, 3'b111, 2'd0, 2500, 1'b0);
    run_mix("sat_pos", 16'h7fff, 16'h7fff, 16'h7fff, 3'b111, 2'd0, 32767, 1'b1);
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    check("clip_cleared", val_t'(clip), 0);
    run_mix("sat_neg", 16'h8000, 16'h8000, 16'h8000, 3'b111, 2'd0, -32768, 1'b1);
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    run_mix("shift2", 16'h7fff, 16'h7fff, 16'h7fff, 3'b111, 2'd2, 24575, 1'b0);
    run_mix("mask010", 16'd5000, -16'sd3, 16'd7000, 3'b010, 2'd1, -2, 1'b0);
    run_mix("floor3", 16'd5000, 16'd6000, -16'sd1, 3'b100, 2'd3, -1, 1'b0);
    run_mix("mask000", 16'd1234, 16'd2345, 16'd3456, 3'b000, 2'd0, 0, 1'b0);

    // Second request two cycles into a mix: ignored, flagged, one pulse only.
    voice_sample_0 = 16'd10; voice_sample_1 = 16'd20; voice_sample_2 = 16'd30;
    voice_active = 3'b111; master_shift = 2'd0;
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    pulses = 0;
    tick();
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mix_valid) pulses++;
      tick();
    end
    check("ovr_pulses", val_t'(pulses), 1);
    check("ovr_flag", val_t'(overrun), 1);
    check("ovr_sample", val_t'($signed(mix_sample)), 60);

    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    check("ovr_cleared", val_t'(overrun), 0);

    // Request landing in SAT counts as busy; clear coincident with overrun keeps it set.
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    repeat (3) tick();
    generate_next_sample = 1'b1;
    clip_clear           = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    clip_clear           = 1'b0;
    check("sat_req_valid", val_t'(mix_valid), 1);
    check("sat_req_overrun", val_t'(overrun), 1);
    check("sat_req_idle", val_t'(busy), 0);

    // Snapshot isolation: voice 0 changes while the mix is in ACC1.
    voice_sample_0 = 16'd100; voice_active = 3'b001; master_shift = 2'd0;
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    tick();
    voice_sample_0 = 16'd9000;
    repeat (3) tick();
    check("snap_valid", val_t'(mix_valid), 1);
    check("snap_sample", val_t'($signed(mix_sample)), 100);
    tick();

    // Reset asserted in ACC2 aborts the mix.
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("abort_sample", val_t'($signed(mix_sample)), 0);
    check("abort_busy", val_t'(busy), 0);
    check("abort_overrun", val_t'(overrun), 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mix_valid) pulses++;
    end
    check("abort_no_valid", val_t'(pulses), 0);
    reset = 1'b1;
    tick();
    run_mix("post_reset", 16'd1, 16'd2, 16'd3, 3'b111, 2'd0, 6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the bit width of each voice sample and of the mixed output (two's complement).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports voice_sample_0, voice_sample_1 and voice_sample_2, each input, WIDTH bits: signed per-voice samples from the dynamics stages.
REQ-005 SHALL have port voice_active, input, 3 bits: per-voice enable mask; bit i gates voice_sample_i.
REQ-006 SHALL have port master_shift, input, 2 bits: master attenuation, arithmetic right shift by 0 to 3.
REQ-007 SHALL have port generate_next_sample, input, 1 bit: single-cycle request from the codec for a new sample.
REQ-008 SHALL have port clip_clear, input, 1 bit: synchronous clear of the sticky clip and overrun flags.
REQ-009 SHALL have port mix_sample, output, WIDTH bits: signed, registered mixed sample.
REQ-010 SHALL have port mix_valid, output, 1 bit: one-cycle pulse marking a new mix_sample.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 SHALL have port clip, output, 1 bit: sticky flag, set when a result saturated.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, set when a request arrived while busy.

Function
REQ-014 The FSM SHALL have exactly five states, IDLE, ACC0, ACC1, ACC2 and SAT, and SHALL advance one state per clock.
REQ-015 On an edge where the FSM is in IDLE and generate_next_sample=1, the block SHALL snapshot all three voice samples, voice_active and master_shift, SHALL clear the accumulator to 0, and SHALL enter ACC0.
REQ-016 In ACCi the block SHALL add the sign-extended snapshot of voice i to an 18-bit signed accumulator if snapshot bit i is 1, otherwise add 0, and SHALL then advance (ACC0 to ACC1 to ACC2 to SAT).
REQ-017 In SAT the block SHALL arithmetic-right-shift the accumulator by the master_shift snapshot, then clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-018 In SAT the block SHALL register the clamped value into mix_sample, SHALL pulse mix_valid for exactly one cycle, and SHALL return to IDLE.
REQ-019 Latency: mix_valid SHALL be high in the 5th cycle after the cycle in which the request was sampled.
REQ-020 mix_sample SHALL hold its value between updates.
REQ-021 Voice inputs that change after the snapshot SHALL NOT affect the result in progress.
REQ-022 clip SHALL be set in SAT whenever clamping changed the value.
REQ-023 A request sampled while busy=1 SHALL be ignored and SHALL set overrun; it SHALL NOT restart or extend the current mix.
REQ-024 A request in the same cycle as the SAT state counts as busy.
REQ-025 clip_clear=1 SHALL clear clip and overrun, except that a set event in the same cycle wins (the flag ends at 1).
REQ-026 voice_active=000 SHALL produce mix_sample=0 with mix_valid still pulsed.
REQ-027 The accumulator SHALL never overflow: the worst case of 3 x 32767 = 98301 fits in 18 bits signed.
REQ-028 The arithmetic shift SHALL round toward negative infinity (for example, -1 >>> 1 = -1).

Reset
REQ-029 While reset=0, asynchronously: the FSM SHALL be in IDLE; mix_sample, the accumulator and the snapshots SHALL be 0; mix_valid, busy, clip and overrun SHALL be 0.
REQ-030 Reset asserted mid-mix SHALL abort the mix with no mix_valid pulse; the first request after release SHALL start a fresh mix.
REQ-031 Release of reset SHALL take effect on the first rising clk edge after reset goes high; no request is lost if it arrives one cycle after release.

Verification
REQ-032 Voices 1000, 2000 and -500, mask 111, shift 0, request pulse -> mix_valid 5 cycles later, mix_sample=2500, clip=0.
REQ-033 All voices 32767, mask 111, shift 0 -> mix_sample=32767, clip=1; then with all voices -32768 -> mix_sample=-32768.
REQ-034 All voices 32767, mask 111, shift 2 -> 98301>>>2 = 24575, clip=0; mask 010 with voice 1 = -3 and shift 1 -> mix_sample=-2.
REQ-035 Request, then a second request 2 cycles later -> exactly one mix_valid, overrun=1; clip_clear coincident with a new overrun event -> overrun stays 1.
REQ-036 Change voice_sample_0 from 100 to 9000 in ACC1 (snapshot was 100; mask 001) -> mix_sample=100.
REQ-037 Assert reset in ACC2 -> no mix_valid, all outputs 0, busy=0; a request after release produces a correct mix 5 cycles later.
